// File: rtl/chess_turn_sequencer.sv
// Two-player chess clock turn sequencer: button edge detection, turn/pause/timeout
// FSM, saturating move counter and a fixed-length end-of-game buzzer pulse.
module chess_turn_sequencer #(
  parameter int unsigned MOVE_W      = 10,
  parameter int unsigned BUZZ_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_btn,
  input  logic              pause_btn,
  input  logic              p1_btn,
  input  logic              p2_btn,
  input  logic              timeout1,
  input  logic              timeout2,
  output logic              enable,
  output logic [1:0]        player,
  output logic              game_over,
  output logic [1:0]        winner,
  output logic [MOVE_W-1:0] move_count,
  output logic              buzzer
);

  localparam int unsigned CNT_W = $clog2(BUZZ_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_P1 = 3'd1,
    RUN_P2 = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t state, state_d;
  state_t resume, resume_d;

  logic start_q, pause_q, p1_q, p2_q;
  logic start_e, pause_e, p1_e, p2_e;

  logic [CNT_W-1:0]  buzz_cnt, buzz_cnt_d;
  logic              enable_d, game_over_d, buzzer_d;
  logic [1:0]        player_d, winner_d;
  logic [MOVE_W-1:0] move_count_d;

  assign start_e = start_btn & ~start_q;
  assign pause_e = pause_btn & ~pause_q;
  assign p1_e    = p1_btn & ~p1_q;
  assign p2_e    = p2_btn & ~p2_q;

  // State, edge history and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resume     <= RUN_P1;
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      enable     <= 1'b0;
      player     <= 2'b00;
      game_over  <= 1'b0;
      winner     <= 2'b00;
      move_count <= '0;
      buzzer     <= 1'b0;
      buzz_cnt   <= '0;
    end else begin
      state      <= state_d;
      resume     <= resume_d;
      start_q    <= start_btn;
      pause_q    <= pause_btn;
      p1_q       <= p1_btn;
      p2_q       <= p2_btn;
      enable     <= enable_d;
      player     <= player_d;
      game_over  <= game_over_d;
      winner     <= winner_d;
      move_count <= move_count_d;
      buzzer     <= buzzer_d;
      buzz_cnt   <= buzz_cnt_d;
    end
  end

  // Next state; in a run state timeout beats the turn button, which beats pause
  always_comb begin
    state_d  = state;
    resume_d = resume;
    unique case (state)
      IDLE:   if (start_e) state_d = RUN_P1;
      RUN_P1: begin
        if (timeout1)     state_d = OVER;
        else if (p1_e)    state_d = RUN_P2;
        else if (pause_e) begin
          state_d  = PAUSED;
          resume_d = RUN_P1;
        end
      end
      RUN_P2: begin
        if (timeout2)     state_d = OVER;
        else if (p2_e)    state_d = RUN_P1;
        else if (pause_e) begin
          state_d  = PAUSED;
          resume_d = RUN_P2;
        end
      end
      PAUSED: if (pause_e) state_d = resume;
      OVER:   if (start_e) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition being taken
  always_comb begin
    enable_d     = 1'b0;
    player_d     = 2'b00;
    game_over_d  = 1'b0;
    winner_d     = winner;
    move_count_d = move_count;
    buzzer_d     = 1'b0;
    buzz_cnt_d   = '0;

    unique case (state_d)
      RUN_P1: begin enable_d = 1'b1; player_d = 2'b01; end
      RUN_P2: begin enable_d = 1'b1; player_d = 2'b10; end
      PAUSED: player_d = (resume_d == RUN_P1) ? 2'b01 : 2'b10;
      OVER:   game_over_d = 1'b1;
      default: ;
    endcase

    if (state_d == IDLE) begin
      winner_d     = 2'b00;
      move_count_d = '0;
    end else if (state == IDLE && state_d == RUN_P1) begin
      move_count_d = '0;
    end else if ((state == RUN_P1 && state_d == RUN_P2) ||
                 (state == RUN_P2 && state_d == RUN_P1)) begin
      if (move_count != {MOVE_W{1'b1}}) move_count_d = move_count + MOVE_W'(1);
    end

    if (state != OVER && state_d == OVER) begin
      winner_d   = (state == RUN_P1) ? 2'b10 : 2'b01;
      buzzer_d   = 1'b1;
      buzz_cnt_d = CNT_W'(BUZZ_CYCLES - 1);
    end else if (state == OVER && state_d == OVER && buzzer) begin
      // buzz_cnt holds the high cycles still owed after the current one
      if (buzz_cnt != '0) begin
        buzzer_d   = 1'b1;
        buzz_cnt_d = buzz_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_chess_turn_sequencer.sv
// Directed bench for chess_turn_sequencer (MOVE_W=3, BUZZ_CYCLES=8).
module tb_chess_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn, pause_btn, p1_btn, p2_btn, timeout1, timeout2;
  logic       enable, game_over, buzzer;
  logic [1:0] player, winner;
  logic [2:0] move_count;

  int n_checks = 0;
  int n_fails  = 0;

  chess_turn_sequencer #(.MOVE_W(3), .BUZZ_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .p1_btn     (p1_btn),
    .p2_btn     (p2_btn),
    .timeout1   (timeout1),
    .timeout2   (timeout2),
    .enable     (enable),
    .player     (player),
    .game_over  (game_over),
    .winner     (winner),
    .move_count (move_count),
    .buzzer     (buzzer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en, input logic [1:0] pl,
                         input logic go, input logic [1:0] wn, input logic [2:0] mc,
                         input logic bz);
    chk({tag, ".enable"}, 32'(enable), 32'(en));
    chk({tag, ".player"}, 32'(player), 32'(pl));
    chk({tag, ".game_over"}, 32'(game_over), 32'(go));
    chk({tag, ".winner"}, 32'(winner), 32'(wn));
    chk({tag, ".move_count"}, 32'(move_count), 32'(mc));
    chk({tag, ".buzzer"}, 32'(buzzer), 32'(bz));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise one button (0 start, 1 pause, 2 p1, 3 p2) and take one clock edge
  task automatic press(input int which);
    case (which)
      0: start_btn = 1'b1;
      1: pause_btn = 1'b1;
      2: p1_btn    = 1'b1;
      default: p2_btn = 1'b1;
    endcase
    step();
  endtask

  task automatic release_all();
    start_btn = 1'b0; pause_btn = 1'b0; p1_btn = 1'b0; p2_btn = 1'b0;
    step();
  endtask

  // Entry cycle is buzzer cycle 1; expect 7 more high cycles then low
  task automatic buzz_run(input string tag);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk({tag, ".buzz_high"}, 32'(buzzer), 32'd1);
    end
    step();
    chk({tag, ".buzz_low"}, 32'(buzzer), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start_btn = 1'b1;  // held through reset release
    pause_btn = 1'b0; p1_btn = 1'b0; p2_btn = 1'b0;
    timeout1 = 1'b0; timeout2 = 1'b0;
    #22;
    chk_all("reset", 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0);
    reset = 1'b0;

    step();
    chk_all("start_held", 1'b1, 2'b01, 1'b0, 2'b00, 3'd0, 1'b0);
    release_all();

    press(2); chk_all("p1_turn", 1'b1, 2'b10, 1'b0, 2'b00, 3'd1, 1'b0); release_all();
    press(3); chk_all("p2_turn", 1'b1, 2'b01, 1'b0, 2'b00, 3'd2, 1'b0); release_all();
    press(3); chk_all("p2_ign_in_p1", 1'b1, 2'b01, 1'b0, 2'b00, 3'd2, 1'b0); release_all();
    press(2); chk_all("p1_turn2", 1'b1, 2'b10, 1'b0, 2'b00, 3'd3, 1'b0); release_all();
    press(2); chk_all("p1_ign_in_p2", 1'b1, 2'b10, 1'b0, 2'b00, 3'd3, 1'b0); release_all();

    press(1); chk_all("pause", 1'b0, 2'b10, 1'b0, 2'b00, 3'd3, 1'b0); release_all();
    press(3); chk_all("paused_p2_ign", 1'b0, 2'b10, 1'b0, 2'b00, 3'd3, 1'b0); release_all();
    timeout2 = 1'b1; step();
    chk_all("paused_to_ign", 1'b0, 2'b10, 1'b0, 2'b00, 3'd3, 1'b0);
    timeout2 = 1'b0;
    press(0); chk_all("paused_start_ign", 1'b0, 2'b10, 1'b0, 2'b00, 3'd3, 1'b0); release_all();
    press(1); chk_all("resume", 1'b1, 2'b10, 1'b0, 2'b00, 3'd3, 1'b0); release_all();

    press(3); chk_all("p2_turn2", 1'b1, 2'b01, 1'b0, 2'b00, 3'd4, 1'b0); release_all();
    timeout2 = 1'b1; step();
    chk_all("inactive_to_ign", 1'b1, 2'b01, 1'b0, 2'b00, 3'd4, 1'b0);
    timeout2 = 1'b0;

    // timeout1 and p1 edge together: timeout wins, no move counted
    timeout1 = 1'b1; p1_btn = 1'b1; step();
    chk_all("timeout1", 1'b0, 2'b00, 1'b1, 2'b10, 3'd4, 1'b1);
    timeout1 = 1'b0; p1_btn = 1'b0;
    buzz_run("buzz1");
    chk_all("over_hold", 1'b0, 2'b00, 1'b1, 2'b10, 3'd4, 1'b0);

    press(0); chk_all("over_to_idle", 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0); release_all();
    press(2); chk_all("idle_p1_ign", 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0); release_all();

    // Saturation: 9 alternating turn ends with a 3-bit counter
    press(0); chk_all("start2", 1'b1, 2'b01, 1'b0, 2'b00, 3'd0, 1'b0); release_all();
    for (int k = 1; k <= 9; k++) begin
      press((k % 2 == 1) ? 2 : 3);
      chk("sat_count", 32'(move_count), (k > 7) ? 32'd7 : 32'(k));
      chk("sat_player", 32'(player), (k % 2 == 1) ? 32'd2 : 32'd1);
      release_all();
    end

    // Async reset mid-RUN_P2 with no clock edge
    #2 reset = 1'b1;
    #1 chk_all("async_run", 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0);
    #1 reset = 1'b0;

    // Early exit from OVER while buzzing
    press(0); release_all();
    press(2); chk_all("p1_turn3", 1'b1, 2'b10, 1'b0, 2'b00, 3'd1, 1'b0); release_all();
    timeout2 = 1'b1; step();
    chk_all("timeout2", 1'b0, 2'b00, 1'b1, 2'b01, 3'd1, 1'b1);
    timeout2 = 1'b0;
    step(); step();
    chk("buzz_mid", 32'(buzzer), 32'd1);
    press(0); chk_all("early_exit", 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0); release_all();
    chk("early_exit_quiet", 32'(buzzer), 32'd0);

    // Async reset mid-OVER with buzzer high
    press(0); release_all();
    timeout1 = 1'b1; step();
    chk_all("timeout1b", 1'b0, 2'b00, 1'b1, 2'b10, 3'd0, 1'b1);
    timeout1 = 1'b0;
    step();
    #2 reset = 1'b1;
    #1 chk_all("async_over", 1'b0, 2'b00, 1'b0, 2'b00, 3'd0, 1'b0);
    #1 reset = 1'b0;

    // A fresh game still gets the full-length pulse
    press(0); release_all();
    timeout1 = 1'b1; step();
    chk_all("timeout1c", 1'b0, 2'b00, 1'b1, 2'b10, 3'd0, 1'b1);
    timeout1 = 1'b0;
    buzz_run("buzz2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/chess_turn_sequencer.md
CHESS_TURN_SEQUENCER -- requirements
Module: chess_turn_sequencer

Interface
REQ-001 Parameter MOVE_W, default 10, SHALL set the width of the move counter.
REQ-002 Parameter BUZZ_CYCLES, default 50000000, SHALL set the buzzer pulse length in clk cycles (1 s at 50 MHz).
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_btn  input  1  debounced, synchronized level; rising edge starts a game or clears a finished one.
REQ-006 pause_btn  input  1  debounced, synchronized level; rising edge toggles pause.
REQ-007 p1_btn / p2_btn  input  1 each  debounced, synchronized levels; rising edge ends that player's turn.
REQ-008 timeout1 / timeout2  input  1 each  level from the player timers; high = that player's time exhausted.
REQ-009 enable  output  1  run request to the timers control block.
REQ-010 player  output  2  active player: 01 = player 1, 10 = player 2, 00 = none.
REQ-011 game_over  output  1  high while in OVER.
REQ-012 winner  output  2  01/10 = winning player, 00 = none.
REQ-013 move_count  output  MOVE_W  completed turns in the current game.
REQ-014 buzzer  output  1  end-of-game alarm pulse.

Function
REQ-015 Edge detection SHALL use one registered copy per button; an edge is in=1 and in_q=0 at a rising clk edge.
REQ-016 All outputs SHALL be registered and change at the same clk edge the causing edge/level is sampled (1-cycle latency from input change).
REQ-017 States SHALL be IDLE, RUN_P1, RUN_P2, PAUSED, OVER.
REQ-018 IDLE: enable=0, player=00, game_over=0, winner=00; start edge -> RUN_P1; all other inputs ignored.
REQ-019 RUN_P1: enable=1, player=01; p1 edge -> RUN_P2 and move_count+1; p2 edge ignored.
REQ-020 RUN_P2: enable=1, player=10; p2 edge -> RUN_P1 and move_count+1; p1 edge ignored.
REQ-021 RUN_Px: timeoutx=1 -> OVER with winner = opponent (timeout1 -> 10, timeout2 -> 01); timeout of the inactive player ignored.
REQ-022 RUN_Px: pause edge -> PAUSED, storing the current run state as resume state.
REQ-023 Same-cycle priority in RUN_Px: timeout > active player's button > pause.
REQ-024 PAUSED: enable=0, player holds the paused player's code; pause edge -> resume state; player buttons, start and timeouts ignored.
REQ-025 OVER: enable=0, player=00, game_over=1, winner held; start edge -> IDLE with move_count=0, winner=00.
REQ-026 move_count SHALL saturate at 2^MOVE_W-1, never wrap, and SHALL be cleared on entry to RUN_P1 from IDLE.
REQ-027 On entry to OVER, buzzer SHALL go high for exactly BUZZ_CYCLES cycles, then low; leaving OVER early SHALL force buzzer low and clear its counter.
REQ-028 Buzzer counter width SHALL be $clog2(BUZZ_CYCLES+1); no other arithmetic beyond move_count increment.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, enable=0, player=00, game_over=0, winner=00, move_count=0, buzzer=0, buzzer counter=0, and all button edge registers to 0, regardless of current state.
REQ-030 A button held high during reset release SHALL produce an edge on the first clock after release (edge registers reset to 0).

Verification
REQ-031 Reset, start pulse -> next edge state RUN_P1, enable=1, player=01, move_count=0.
REQ-032 In RUN_P1, p1 edge, then p2 edge, then p1 edge -> player 10, 01, 10; move_count=3.
REQ-033 In RUN_P2, pause edge -> enable=0, player=10; p2 edge and timeout2=1 ignored; pause edge -> enable=1, player=10, move_count unchanged.
REQ-034 In RUN_P1, timeout1=1 and p1 edge same cycle -> OVER, winner=10, game_over=1, move_count unchanged, buzzer high for BUZZ_CYCLES (bench sets BUZZ_CYCLES=8) then low.
REQ-035 MOVE_W=3, 9 alternating presses -> move_count saturates at 7; start edge in OVER -> IDLE, move_count=0.
REQ-036 Assert reset mid-RUN_P2 with buzzer idle and mid-OVER with buzzer high -> all outputs reset within the same cycle, no clk edge required.
